// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the per-axis segment state type.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   // 640x480 @ 60 Hz defaults
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOT_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOT_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   // Sync windows: start inclusive, end exclusive
   localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
   localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

   // Level driven on hsync/vsync during the pulse (0 = negative sync)
   localparam logic SYNC_ACTIVE_DEF = 1'b0;

   // Segment of one axis; order follows the scan direction
   typedef enum logic [1:0] {
      AX_ACTIVE = 2'd0,
      AX_FRONT  = 2'd1,
      AX_SYNC   = 2'd2,
      AX_BACK   = 2'd3
   } axis_state_t;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Timing bundle between the VGA timing controller and its consumers.
// There is no valid/ready handshake: en is a level qualifier that advances
// the timing by one pixel on each rising clk edge where it is high, and all
// other signals are registered outputs that are valid every cycle.
interface vga_timing_ctrl_if;
   import vga_timing_pkg::*;

   logic             en;
   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             hsync;
   logic             vsync;
   logic             active;
   logic             line_tick;
   logic             frame_tick;
   logic             vblank;

   // Timing generator side
   modport master (
      input  en,
      output hcount, vcount, hsync, vsync, active, line_tick, frame_tick, vblank
   );

   // Consumer side (pixel-colour / game-state logic)
   modport slave (
      output en,
      input  hcount, vcount, hsync, vsync, active, line_tick, frame_tick, vblank
   );

endinterface

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping counter plus ACTIVE->FRONT->SYNC->BACK segment FSM.
module vga_axis_cnt
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = H_ACTIVE_DEF,
   parameter int FP     = H_FP_DEF,
   parameter int SYNC   = H_SYNC_DEF,
   parameter int BP     = H_BP_DEF
) (
   input  logic             clk,
   input  logic             greset,
   input  logic             step_i,
   output logic [CNT_W-1:0] count_o,
   output axis_state_t      state_o,
   output axis_state_t      state_nxt_o,
   output logic             wrap_o,
   output logic             in_sync_o
);

   localparam int TOT = ACTIVE + FP + SYNC + BP;

   // Last count of each segment; the FSM leaves a segment when stepping past it
   localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(ACTIVE - 1);
   localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(ACTIVE + FP - 1);
   localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(ACTIVE + FP + SYNC - 1);
   localparam logic [CNT_W-1:0] END_BACK   = CNT_W'(TOT - 1);

   logic [CNT_W-1:0] count_q, count_d;
   axis_state_t      state_q, state_d;

   assign wrap_o = (count_q == END_BACK);

   // Next count and next segment; both hold when not stepping
   always_comb begin
      count_d = count_q;
      state_d = state_q;
      if (step_i) begin
         count_d = wrap_o ? '0 : count_q + CNT_W'(1);
         case (state_q)
            AX_ACTIVE: if (count_q == END_ACTIVE) state_d = AX_FRONT;
            AX_FRONT:  if (count_q == END_FRONT)  state_d = AX_SYNC;
            AX_SYNC:   if (count_q == END_SYNC)   state_d = AX_BACK;
            AX_BACK:   if (count_q == END_BACK)   state_d = AX_ACTIVE;
         endcase
      end
   end

   // Counter and state register; reset parks on the last count of the frame
   always_ff @(posedge clk) begin
      if (greset) begin
         count_q <= END_BACK;
         state_q <= AX_BACK;
      end else begin
         count_q <= count_d;
         state_q <= state_d;
      end
   end

   assign count_o     = count_q;
   assign state_o     = state_q;
   assign state_nxt_o = state_d;
   assign in_sync_o   = (state_d == AX_SYNC);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: two axis counters plus registered sync/blank/tick decode.
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE    = H_ACTIVE_DEF,
   parameter int   H_FP        = H_FP_DEF,
   parameter int   H_SYNC      = H_SYNC_DEF,
   parameter int   H_BP        = H_BP_DEF,
   parameter int   V_ACTIVE    = V_ACTIVE_DEF,
   parameter int   V_FP        = V_FP_DEF,
   parameter int   V_SYNC      = V_SYNC_DEF,
   parameter int   V_BP        = V_BP_DEF,
   parameter logic SYNC_ACTIVE = SYNC_ACTIVE_DEF
) (
   input  logic                clk,
   input  logic                greset,
   vga_timing_ctrl_if.master   vga,
   output axis_state_t         h_state_o,
   output axis_state_t         v_state_o,
   output logic                frame_end_o
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [CNT_W-1:0] V_LAST_ACTIVE = CNT_W'(V_ACTIVE - 1);

   if (H_TOT > 1024 || V_TOT > 1024) begin : g_size_check
      $error("vga_timing_ctrl: H_TOT/V_TOT exceed the 10-bit counters");
   end

   logic [CNT_W-1:0] h_count, v_count;
   axis_state_t      h_state_nxt, v_state_nxt;
   logic             h_wrap, v_wrap, h_in_sync, v_in_sync, v_step;

   // The vertical axis advances on the last pixel of each line
   assign v_step = vga.en & h_wrap;

   vga_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
      .clk        (clk),
      .greset     (greset),
      .step_i     (vga.en),
      .count_o    (h_count),
      .state_o    (h_state_o),
      .state_nxt_o(h_state_nxt),
      .wrap_o     (h_wrap),
      .in_sync_o  (h_in_sync)
   );

   vga_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
      .clk        (clk),
      .greset     (greset),
      .step_i     (v_step),
      .count_o    (v_count),
      .state_o    (v_state_o),
      .state_nxt_o(v_state_nxt),
      .wrap_o     (v_wrap),
      .in_sync_o  (v_in_sync)
   );

   logic hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
   logic line_tick_q, line_tick_d, frame_tick_q, frame_tick_d, vblank_q, vblank_d;

   // Decode from the next axis states so outputs land in the same cycle as the counts
   always_comb begin
      hsync_d      = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d      = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      active_d     = (h_state_nxt == AX_ACTIVE) && (v_state_nxt == AX_ACTIVE);
      vblank_d     = (v_state_nxt != AX_ACTIVE);
      // Ticks only fire on an enabled step, so a stalled cycle never repeats them
      line_tick_d  = vga.en & h_wrap;
      frame_tick_d = line_tick_d & (v_count == V_LAST_ACTIVE);
   end

   // Output registers; reset values equal the decode of the last pixel of a frame
   always_ff @(posedge clk) begin
      if (greset) begin
         hsync_q      <= ~SYNC_ACTIVE;
         vsync_q      <= ~SYNC_ACTIVE;
         active_q     <= 1'b0;
         vblank_q     <= 1'b1;
         line_tick_q  <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         active_q     <= active_d;
         vblank_q     <= vblank_d;
         line_tick_q  <= line_tick_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign vga.hcount     = h_count;
   assign vga.vcount     = v_count;
   assign vga.hsync      = hsync_q;
   assign vga.vsync      = vsync_q;
   assign vga.active     = active_q;
   assign vga.vblank     = vblank_q;
   assign vga.line_tick  = line_tick_q;
   assign vga.frame_tick = frame_tick_q;
   assign frame_end_o    = h_wrap & v_wrap;

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the 25 MHz pixel clock produced by the lab clock block into standard VGA timing: 640x480 at 60 Hz, 800x525 total.
- Produces pixel/line counters, registered hsync/vsync, an active-video flag, and one-cycle line/frame ticks.
- Game and pixel logic uses these ticks to schedule updates during vertical blanking.
- Sits between the clock block and the pixel-colour and game-state logic in the top level.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hsync/vsync during the sync pulse

Ports:
- clk  in  1  pixel clock (25 MHz); every register in the block is clocked on its rising edge
- greset  in  1  synchronous, active-high reset
- en  in  1  advance enable; tied high in the lab top level; when low, all state holds
- hcount  out  10  current pixel column, 0..H_TOT-1
- vcount  out  10  current line, 0..V_TOT-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE
- line_tick  out  1  one-cycle pulse in the cycle where hcount==0
- frame_tick  out  1  one-cycle pulse in the cycle where hcount==0 and vcount==V_ACTIVE (start of vblank)
- vblank  out  1  high while vcount>=V_ACTIVE

Behaviour:
- Totals: H_TOT = sum of the four H parameters = 800; V_TOT = sum of the four V parameters = 525.
- Reset (greset=1 at a clk edge):
  - hcount=H_TOT-1 (799), vcount=V_TOT-1 (524).
  - hsync and vsync = !SYNC_ACTIVE; active=0, line_tick=0, frame_tick=0, vblank=1.
  - These values equal the decode of (799,524), so reset values and steady-state decode agree.
- Counting, on an edge with greset=0 and en=1:
  - hcount increments; at H_TOT-1 it wraps to 0.
  - On that wrap, vcount increments; at V_TOT-1 it wraps to 0.
  - First enabled edge after reset reaches (0,0) with active=1 and line_tick=1.
- Alignment: every decoded output is registered, computed from the next counter values. Outputs are therefore cycle-aligned with hcount/vcount, with no skew.
- hsync = SYNC_ACTIVE iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync = SYNC_ACTIVE iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line, independent of hcount.
- Per-axis state machine, one per counter, states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE:
  - Each transition occurs when the axis count reaches the end of its segment.
  - The state must match the count-range decode at all times; the bench checks this with assertions.
- en=0: counters, state and all outputs hold. line_tick and frame_tick are forced to 0 on any edge with en=0, so each tick lasts exactly one enabled cycle and is never repeated.
- greset has priority over en.
- Reset mid-frame: the next edge loads the reset values, with no partial-frame completion.
- Width rule: 10-bit counters. Elaboration-time check: H_TOT<=1024 and V_TOT<=1024, otherwise $error.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants and derived totals/sync boundaries
  - axis-state enum {ACTIVE, FRONT, SYNC, BACK}
- Sub-module vga_axis_cnt is instantiated twice, once per axis:
  - parameters: ACTIVE, FP, SYNC, BP
  - inputs: clk, greset, step
  - outputs: count, state, wrap, in_sync
  - horizontal instance: step=en; vertical instance: step=en & h_wrap.

Test Plan:
- Reset held 3 cycles, then en=1 -> during reset (799,524), hsync=vsync=1, active=0; first edge after release (0,0), active=1, line_tick=1.
- Free run one line -> active high for exactly 640 cycles; hsync low at hcount 656..751 (96 cycles); line_tick period 800 cycles.
- Free run two frames -> frame_tick period exactly 420000 cycles; vsync low for 1600 cycles (lines 490-491); vblank high 45 lines.
- en toggled 1,0,0,1 at hcount=799 -> counters hold at 799 for two cycles, then wrap to 0; line_tick high for exactly one cycle.
- greset asserted at (320,240) -> next edge (799,524) with reset output values; counting resumes cleanly from (0,0).
- SYNC_ACTIVE=1 override -> hsync/vsync polarity inverted; all other outputs identical to the default run.
